fifo_rd_packer: RTL

//  Read-side consumer for async_fifo: drains bytes from the FIFO read port and

---
 rtl/fifo_rd_packer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// =============================================================================
// Module   : fifo_rd_packer
// Purpose  : Drains async_fifo read port, packs LANES entries per output word.
//            Optional idle flush of partial words: FIFO_RD_PACKER_FLUSH_EN.
// Revision : 1.0  initial release
// =============================================================================
module fifo_rd_packer #(
    parameter int WIDTH         = 8,
    parameter int LANES         = 4,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                         rclk,
    input  logic                         rrst_n,
    input  logic                         empty,
    input  logic [WIDTH-1:0]             data_out,
    output logic                         r_en,
    output logic [WIDTH*LANES-1:0]       pk_data,
    output logic                         pk_valid,
    input  logic                         pk_ready,
    output logic [$clog2(LANES+1)-1:0]   pk_bytes,
    output logic [15:0]                  word_cnt
);

    localparam int CNT_W = $clog2(LANES+1);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
    localparam logic [CNT_W:0]   LANES_W = (CNT_W+1)'(LANES);

    if (LANES < 2 || FLUSH_TIMEOUT < 1) begin : g_bad_cfg
        $fatal(1, "fifo_rd_packer: LANES must be >= 2 and FLUSH_TIMEOUT >= 1");
    end

    typedef enum logic [0:0] {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     inflight_q, inflight_d;
    logic [WIDTH*LANES-1:0]   pk_data_q, pk_data_d;
    logic                     pk_valid_q, pk_valid_d;
    logic [CNT_W-1:0]         pk_bytes_q, pk_bytes_d;
    logic [15:0]              word_cnt_q, word_cnt_d;
    logic [CNT_W:0]           occupancy;

`ifdef FIFO_RD_PACKER_FLUSH_EN
    localparam int TMR_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(FLUSH_TIMEOUT - 1);
    logic [TMR_W-1:0]         timer_q, timer_d;
`endif

    // Outstanding read counts toward the lane budget so we never over-read.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign r_en      = rrst_n && (state_q == FILL) && !empty && (occupancy < LANES_W);

    assign pk_data  = pk_data_q;
    assign pk_valid = pk_valid_q;
    assign pk_bytes = pk_bytes_q;
    assign word_cnt = word_cnt_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = r_en;
        pk_data_d  = pk_data_q;
        pk_valid_d = pk_valid_q;
        pk_bytes_d = pk_bytes_q;
        word_cnt_d = word_cnt_q;
`ifdef FIFO_RD_PACKER_FLUSH_EN
        timer_d    = timer_q;
`endif
        case (state_q)
            FILL: begin
                if (inflight_q) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (count_q == CNT_W'(k)) begin
                            pk_data_d[k*WIDTH +: WIDTH] = data_out;
                        end
                    end
                    count_d = count_q + 1'b1;
                    if (count_d == LANES_C) begin
                        state_d    = EMIT;
                        pk_valid_d = 1'b1;
                        pk_bytes_d = LANES_C;
                    end
                end
`ifdef FIFO_RD_PACKER_FLUSH_EN
                if (inflight_q || !empty || (count_q == '0)) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    timer_d    = '0;
                    state_d    = EMIT;
                    pk_valid_d = 1'b1;
                    pk_bytes_d = count_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            EMIT: begin
                if (pk_valid_q && pk_ready) begin
                    state_d    = FILL;
                    pk_valid_d = 1'b0;
                    count_d    = '0;
                    pk_data_d  = '0;
                    pk_bytes_d = '0;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= FILL;
            count_q    <= '0;
            inflight_q <= 1'b0;
            pk_data_q  <= '0;
            pk_valid_q <= 1'b0;
            pk_bytes_q <= '0;
            word_cnt_q <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            pk_data_q  <= pk_data_d;
            pk_valid_q <= pk_valid_d;
            pk_bytes_q <= pk_bytes_d;
            word_cnt_q <= word_cnt_d;
`ifdef FIFO_RD_PACKER_FLUSH_EN
            timer_q    <= timer_d;
`endif
        end
    end

endmodule
`default_nettype wire
